pe_out_drain: RTL
=================

# pe_out_drain

Output-side reader for the PE array: walks every column of the X_DIM×Y_DIM array and drives the one-hot per-row column select consumed by the array's pe2buf output muxes. For each column it snapshots the X_DIM selected 2·DATA_WIDTH results and streams them, one word per handshake, into the output-feature-map buffer with a computed address. The block sits between the PE array outputs and the output buffer write port, and is started by the layer controller once accumulation is complete.

## Interface
- X_DIM, 15: PE rows; also the number of pe_out words per column.
- Y_DIM, 15: PE columns; also the width of the one-hot column select.
- DATA_WIDTH, 8: operand width; results are 2·DATA_WIDTH.
- ADDR_WIDTH, 8: output buffer address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a drain. Sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  buffer address of element (row 0, col 0). Captured at start.
- pe_out  in  [X_DIM-1:0] × 2·DATA_WIDTH  per-row muxed PE results.
- col_sel  out  Y_DIM  one-hot column select, fanned to every row's pe2buf mux.
- buf_valid  out  1  write word valid.
- buf_ready  in  1  buffer accepts the word.
- buf_data  out  2·DATA_WIDTH  write data.
- buf_addr  out  ADDR_WIDTH  write address.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- FSM states: IDLE, SEL, CAP, SEND, FIN.
- IDLE: col_sel=0, buf_valid=0. start=1 → SEL, with col=0, row=0, and base captured.
- SEL (1 cycle): col_sel = 1<<col. This cycle lets the array mux settle.
- CAP (1 cycle): col_sel is held. At the exit edge, all X_DIM pe_out words are latched into the holding registers hold[0..X_DIM-1].
- SEND:
  - buf_valid=1, buf_data=hold[row], buf_addr = base + col·X_DIM + row (mod 2^ADDR_WIDTH, silent wrap).
  - col_sel remains asserted.
  - On valid&&ready: row++. When row==X_DIM-1 is accepted: if col<Y_DIM-1 then col++, row=0 → SEL; else → FIN.
- FIN (1 cycle): done=1, busy=1, col_sel=0 → IDLE.
- Handshake rules:
  - While valid && !ready, buf_data and buf_addr are held stable.
  - buf_valid is never withdrawn before acceptance.
  - Backpressure of any length is allowed.
- start while busy (SEL/CAP/SEND/FIN) is ignored and not queued.
- start in the same cycle as FIN's return is not accepted; it must be presented in IDLE.
- Reset (any state, including mid-SEND) → IDLE immediately. The partially drained column is dropped and no done pulse is issued.
- Reset values: col_sel=0, buf_valid=0, buf_data=0, buf_addr=0, busy=0, done=0, and all hold registers=0.

## Timing
- start sampled high at edge E0. Then:
  - SEL in cycle 1.
  - CAP in cycle 2.
  - First buf_valid in cycle 3.
- With buf_ready tied high:
  - Each column takes X_DIM+2 cycles.
  - done is high in cycle Y_DIM·(X_DIM+2)+1 after E0. That is cycle 256 for the defaults.
- Each cycle of buf_ready low inside SEND adds exactly one cycle.
- col_sel changes only on entry to SEL and on entry to FIN/IDLE. It is constant through CAP and SEND.
- All outputs are registered; no combinational path from buf_ready to buf_valid.

## Structure
- Package pe_drain_pkg holds:
  - the state enum (IDLE, SEL, CAP, SEND, FIN);
  - localparams for row/column counter widths ($clog2(X_DIM), $clog2(Y_DIM));
  - the result width 2·DATA_WIDTH.
- No sub-module is needed. The address is computed as a registered increment (addr+1 per accepted word), not with a multiplier.

## Test plan
- Defaults, pe_out[i] = {col,i} pattern, buf_ready=1 → 225 words in order col-major/row-minor, addresses base..base+224, done pulses in cycle 256, and busy falls the same cycle done falls.
- buf_ready toggling 1-of-3 → identical data/address sequence; data and address are stable during every stall; total cycles grow by exactly the number of stall cycles.
- base_addr=8'hF0 with defaults → address wraps after 8'hFF to 8'h00 without a glitch; the word count is unchanged.
- Change pe_out during SEND → streamed words equal the values present in the CAP cycle, not the live inputs.
- start pulsed during SEND and during FIN → ignored; exactly one done pulse; a new drain starts only from an IDLE start.
- rst asserted mid-column (row 7 of col 3) → all outputs zero asynchronously, no done pulse; a subsequent start drains from col 0 and row 0.

Source files
------------

// File: rtl/pe_drain_pkg.sv
// rtl/pe_drain_pkg.sv - shared types, default sizes and counter widths for the PE output drain
package pe_drain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CAP,
        SEND,
        FIN
    } state_e;

    localparam int DEF_X_DIM      = 15;
    localparam int DEF_Y_DIM      = 15;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    // Counter width that stays at least one bit for degenerate 1-row/1-column arrays
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = cnt_w(DEF_X_DIM);
    localparam int COL_W = cnt_w(DEF_Y_DIM);
    localparam int RES_W = 2 * DEF_DATA_WIDTH;

endpackage

// File: rtl/pe_out_drain.sv
// rtl/pe_out_drain.sv - walks PE array columns, snapshots each column and streams it to the output buffer
module pe_out_drain
    import pe_drain_pkg::*;
#(
    parameter int X_DIM      = DEF_X_DIM,
    parameter int Y_DIM      = DEF_Y_DIM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [X_DIM-1:0][2*DATA_WIDTH-1:0]   pe_out,
    output logic [Y_DIM-1:0]                     col_sel,
    output logic                                 buf_valid,
    input  logic                                 buf_ready,
    output logic [2*DATA_WIDTH-1:0]              buf_data,
    output logic [ADDR_WIDTH-1:0]                buf_addr,
    output logic                                 busy,
    output logic                                 done
);

    localparam int RW = cnt_w(X_DIM);
    localparam int CW = cnt_w(Y_DIM);
    localparam int DW = 2 * DATA_WIDTH;
    localparam logic [RW-1:0]    ROW_LAST = RW'(X_DIM - 1);
    localparam logic [CW-1:0]    COL_LAST = CW'(Y_DIM - 1);
    localparam logic [Y_DIM-1:0] SEL0     = Y_DIM'(1);

    state_e                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [Y_DIM-1:0]        col_sel_q, col_sel_d;
    logic                    valid_q, valid_d;
    logic [DW-1:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DW-1:0]           hold_q [X_DIM];

    logic [RW-1:0] row_inc;
    logic [CW-1:0] col_inc;
    logic          accept;

    assign row_inc = row_q + 1'b1;
    assign col_inc = col_q + 1'b1;
    assign accept  = valid_q && buf_ready;

    // The address is a running linear index, so base + col*X_DIM + row needs no multiplier
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        col_sel_d = col_sel_q;
        valid_d   = valid_q;
        data_d    = data_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEL;
                    row_d     = '0;
                    col_d     = '0;
                    addr_d    = base_addr;
                    col_sel_d = SEL0;
                    busy_d    = 1'b1;
                end
            end
            SEL: state_d = CAP;
            CAP: begin
                state_d = SEND;
                valid_d = 1'b1;
                data_d  = pe_out[0];
            end
            SEND: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        valid_d = 1'b0;
                        row_d   = '0;
                        if (col_q == COL_LAST) begin
                            state_d   = FIN;
                            col_sel_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = SEL;
                            col_d     = col_inc;
                            col_sel_d = SEL0 << col_inc;
                        end
                    end else begin
                        row_d  = row_inc;
                        data_d = hold_q[row_inc];
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            col_sel_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            col_sel_q <= col_sel_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Snapshot taken at the CAP exit edge; the array mux has had the whole SEL cycle to settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < X_DIM; i++) hold_q[i] <= '0;
        end else if (state_q == CAP) begin
            for (int i = 0; i < X_DIM; i++) hold_q[i] <= pe_out[i];
        end
    end

    assign col_sel   = col_sel_q;
    assign buf_valid = valid_q;
    assign buf_data  = data_q;
    assign buf_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
